// File: rtl/sitcp_tx_pkg.sv
// Shared constants for the SiTCP TX concentrator: sync byte, header length
// and the frame FSM state encoding.
package sitcp_tx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         HDR_LEN   = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR0  = 3'd1;
    localparam logic [2:0] ST_HDR1  = 3'd2;
    localparam logic [2:0] ST_HDR2  = 3'd3;
    localparam logic [2:0] ST_PAYLD = 3'd4;

endpackage

// File: rtl/sitcp_tx_chfifo.sv
// Per-channel synchronous FIFO with registered read data (one-cycle read
// latency), occupancy count, full/empty flags and a registered prog-full flag.
module sitcp_tx_chfifo #(
    parameter int W        = 16,
    parameter int AW       = 10,
    parameter int PFULL_TH = 960
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [W-1:0]  din_i,
    input  logic          re_i,
    output logic [W-1:0]  dout_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          pfull_o
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  dout_q;
    logic          pfull_q;
    logic          wr_ok, rd_ok;

    assign full_o  = (count_q == DEPTH);
    assign empty_o = (count_q == '0);
    // A write to a full FIFO is dropped even when a read frees a slot this cycle.
    assign wr_ok   = we_i & ~full_o & ~clr_i;
    assign rd_ok   = re_i & ~empty_o & ~clr_i;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            pfull_q <= 1'b0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            pfull_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + 1'b1;
                dout_q <= mem_q[rptr_q];
            end
            count_q <= count_d;
            pfull_q <= (int'(count_d) >= PFULL_TH);
        end
    end

    assign dout_o  = dout_q;
    assign count_o = count_q;
    assign pfull_o = pfull_q;

endmodule

// File: rtl/sitcp_tx_mux.sv
// N-channel TX concentrator for the SiTCP byte port: per-channel FIFOs,
// round-robin burst arbitration and an optionally framed MSB-first serialiser.
module sitcp_tx_mux
    import sitcp_tx_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int IN_BYTES  = 2,
    parameter int FIFO_AW   = 10,
    parameter int PFULL_TH  = 960,
    parameter int MAX_BURST = 64,
    parameter int FRAMED    = 1
) (
    input  logic                       CLK,
    input  logic                       SYS_RSTn,
    input  logic                       SOFT_RESET,
    input  logic                       TCP_OPEN_ACK,
    input  logic [N_CH-1:0]            CH_WE,
    input  logic [N_CH*IN_BYTES*8-1:0] CH_DATA,
    output logic [N_CH-1:0]            CH_PFULL,
    output logic [N_CH-1:0]            CH_OVF,
    input  logic                       TCP_TX_FULL,
    output logic                       TCP_TX_WR,
    output logic [7:0]                 TCP_TX_DATA,
    output logic                       BUSY
);

    localparam int W  = IN_BYTES * 8;
    localparam int CW = FIFO_AW + 1;

    logic            flush;
    logic [N_CH-1:0] rd_en, fifo_full, fifo_empty, fifo_pfull;
    logic [W-1:0]    fifo_dout [N_CH];
    logic [CW-1:0]   fifo_cnt  [N_CH];

    logic [2:0] state_q, state_d;
    logic [3:0] ch_q, ch_d, rr_q, rr_d;
    logic [7:0] len_q, len_d, words_q, words_d;
    logic [1:0] byte_q, byte_d;
    logic       wr_q, wr_d;
    logic [7:0] data_q, data_d;
    logic [N_CH-1:0] ovf_q;

    logic          gnt_found;
    logic [3:0]    gnt_ch, rd_ch;
    logic [CW-1:0] gnt_cnt;
    logic [7:0]    gnt_len;
    logic [W-1:0]  cur_word;
    logic [7:0]    cur_byte;
    logic          rd_req;

    assign flush = SOFT_RESET | ~TCP_OPEN_ACK;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        sitcp_tx_chfifo #(.W(W), .AW(FIFO_AW), .PFULL_TH(PFULL_TH)) u_fifo (
            .clk_i   (CLK),
            .rst_ni  (SYS_RSTn),
            .clr_i   (flush),
            .we_i    (CH_WE[gi]),
            .din_i   (CH_DATA[gi*W +: W]),
            .re_i    (rd_en[gi]),
            .dout_o  (fifo_dout[gi]),
            .count_o (fifo_cnt[gi]),
            .full_o  (fifo_full[gi]),
            .empty_o (fifo_empty[gi]),
            .pfull_o (fifo_pfull[gi])
        );
    end

    // First non-empty channel at or above the RR pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        gnt_cnt   = '0;
        for (int k = 0; k < N_CH; k++) begin
            for (int j = 0; j < N_CH; j++) begin
                if (!gnt_found && !fifo_empty[j] && (j == (int'(rr_q) + k) % N_CH)) begin
                    gnt_found = 1'b1;
                    gnt_ch    = 4'(j);
                    gnt_cnt   = fifo_cnt[j];
                end
            end
        end
        gnt_len = (int'(gnt_cnt) > MAX_BURST) ? 8'(MAX_BURST) : 8'(gnt_cnt);
    end

    always_comb begin
        cur_word = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (ch_q == 4'(j)) cur_word = fifo_dout[j];
        end
        cur_byte = '0;
        for (int b = 0; b < IN_BYTES; b++) begin
            if (byte_q == 2'(b)) cur_byte = cur_word[b*8 +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        len_d   = len_q;
        words_d = words_q;
        byte_d  = byte_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        rd_req  = 1'b0;
        if (!TCP_TX_FULL) begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        ch_d    = gnt_ch;
                        len_d   = gnt_len;
                        words_d = gnt_len;
                        byte_d  = 2'(IN_BYTES - 1);
                        if (FRAMED != 0) begin
                            state_d = ST_HDR0;
                        end else begin
                            state_d = ST_PAYLD;
                            rd_req  = 1'b1;
                        end
                    end
                end
                ST_HDR0: begin
                    wr_d    = 1'b1;
                    data_d  = SYNC_BYTE;
                    state_d = ST_HDR1;
                end
                ST_HDR1: begin
                    wr_d    = 1'b1;
                    data_d  = {4'h0, ch_q};
                    state_d = ST_HDR2;
                end
                ST_HDR2: begin
                    // Prefetch word 0 so payload starts without a bubble.
                    wr_d    = 1'b1;
                    data_d  = len_q;
                    rd_req  = 1'b1;
                    state_d = ST_PAYLD;
                end
                ST_PAYLD: begin
                    wr_d   = 1'b1;
                    data_d = cur_byte;
                    if (byte_q == 2'd0) begin
                        if (words_q > 8'd1) begin
                            rd_req  = 1'b1;
                            words_d = words_q - 8'd1;
                            byte_d  = 2'(IN_BYTES - 1);
                        end else begin
                            state_d = ST_IDLE;
                            rr_d    = (int'(ch_q) == N_CH - 1) ? 4'd0 : ch_q + 4'd1;
                        end
                    end else begin
                        byte_d = byte_q - 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rd_ch = (state_q == ST_IDLE) ? gnt_ch : ch_q;
    always_comb begin
        rd_en = '0;
        for (int j = 0; j < N_CH; j++) begin
            rd_en[j] = rd_req && (rd_ch == 4'(j));
        end
    end

    always_ff @(posedge CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            rr_q    <= '0;
            len_q   <= '0;
            words_q <= '0;
            byte_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            ovf_q   <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            rr_q    <= '0;
            len_q   <= '0;
            words_q <= '0;
            byte_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            words_q <= words_d;
            byte_q  <= byte_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_q | (CH_WE & fifo_full);
        end
    end

    assign CH_PFULL    = fifo_pfull;
    assign CH_OVF      = ovf_q;
    assign TCP_TX_WR   = wr_q;
    assign TCP_TX_DATA = data_q;
    assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sitcp_tx_mux.sv
// Bench for sitcp_tx_mux: a framed instance checked by a stream parser against
// per-channel word queues, and a raw (FRAMED=0) instance for the unframed case.
module tb_sitcp_tx_mux;
    import sitcp_tx_pkg::*;

    localparam int N_CH = 4;
    localparam int W    = 16;
    localparam int MAXB = 64;

    logic            CLK = 1'b0;
    logic            SYS_RSTn, SOFT_RESET, TCP_OPEN_ACK, TCP_TX_FULL;
    logic [N_CH-1:0] CH_WE, CH_PFULL, CH_OVF;
    logic [N_CH*W-1:0] CH_DATA;
    logic            TCP_TX_WR, BUSY;
    logic [7:0]      TCP_TX_DATA;

    logic [N_CH-1:0]   raw_we, raw_pfull, raw_ovf;
    logic [N_CH*W-1:0] raw_data;
    logic              raw_full, raw_wr, raw_busy;
    logic [7:0]        raw_byte;

    always #5 CLK = ~CLK;

    sitcp_tx_mux #(.N_CH(N_CH), .IN_BYTES(2), .FIFO_AW(10), .PFULL_TH(960),
                   .MAX_BURST(MAXB), .FRAMED(1)) dut (
        .CLK(CLK), .SYS_RSTn(SYS_RSTn), .SOFT_RESET(SOFT_RESET), .TCP_OPEN_ACK(TCP_OPEN_ACK),
        .CH_WE(CH_WE), .CH_DATA(CH_DATA), .CH_PFULL(CH_PFULL), .CH_OVF(CH_OVF),
        .TCP_TX_FULL(TCP_TX_FULL), .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA), .BUSY(BUSY));

    sitcp_tx_mux #(.N_CH(N_CH), .IN_BYTES(2), .FIFO_AW(10), .PFULL_TH(960),
                   .MAX_BURST(MAXB), .FRAMED(0)) dut_raw (
        .CLK(CLK), .SYS_RSTn(SYS_RSTn), .SOFT_RESET(SOFT_RESET), .TCP_OPEN_ACK(TCP_OPEN_ACK),
        .CH_WE(raw_we), .CH_DATA(raw_data), .CH_PFULL(raw_pfull), .CH_OVF(raw_ovf),
        .TCP_TX_FULL(raw_full), .TCP_TX_WR(raw_wr), .TCP_TX_DATA(raw_byte), .BUSY(raw_busy));

    int total = 0;
    int bad   = 0;

    typedef struct { int ch; int len; } frm_t;
    logic [W-1:0] exp_q [N_CH][$];
    frm_t         exp_frm[$];
    logic [7:0]   exp_raw[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h where nothing was expected", name, act);
    endtask

    // ---------------- monitor: parse framed stream ----------------
    logic full_seen  = 1'b0;
    logic flush_seen = 1'b1;
    int   pst = 0, m_ch = 0, m_len = 0, m_words = 0, m_bidx = 0;
    logic [W-1:0] m_word;
    frm_t ef;

    always @(posedge CLK) begin
        full_seen  <= TCP_TX_FULL;
        flush_seen <= SOFT_RESET || !TCP_OPEN_ACK || !SYS_RSTn;
    end

    always @(negedge CLK) begin
        if (flush_seen) begin
            chk("flush_wr", TCP_TX_WR, 1'b0);
            pst = 0;
            for (int i = 0; i < N_CH; i++) exp_q[i].delete();
            exp_frm.delete();
        end else if (TCP_TX_WR) begin
            chk("bp_wr", full_seen, 1'b0);
            case (pst)
                0: begin
                    chk("sync", TCP_TX_DATA, SYNC_BYTE);
                    pst = 1;
                end
                1: begin
                    m_ch = int'(TCP_TX_DATA);
                    chk("hdr_ch_range", m_ch < N_CH, 1'b1);
                    if (m_ch >= N_CH) m_ch = 0;
                    pst = 2;
                end
                2: begin
                    m_len = int'(TCP_TX_DATA);
                    chk("len_range", (m_len >= 1) && (m_len <= MAXB), 1'b1);
                    chk("len_le_pending", m_len <= exp_q[m_ch].size(), 1'b1);
                    if (exp_frm.size() > 0) begin
                        ef = exp_frm.pop_front();
                        chk("frm_ch", m_ch, ef.ch);
                        chk("frm_len", m_len, ef.len);
                    end
                    m_words = 0;
                    m_bidx  = 0;
                    pst = (m_len == 0) ? 0 : 3;
                end
                default: begin
                    m_word = {m_word[7:0], TCP_TX_DATA};
                    m_bidx++;
                    if (m_bidx == 2) begin
                        m_bidx = 0;
                        m_words++;
                        if (exp_q[m_ch].size() == 0) fail("payload_extra", m_word);
                        else chk("payload", m_word, exp_q[m_ch].pop_front());
                        if (m_words == m_len) pst = 0;
                    end
                end
            endcase
        end else if (pst != 0 && !full_seen) begin
            fail("gap_in_frame", pst);
            pst = 0;
        end
    end

    always @(negedge CLK) begin
        if (raw_wr) begin
            if (exp_raw.size() == 0) fail("raw_extra", raw_byte);
            else chk("raw_byte", raw_byte, exp_raw.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic cyc_d(input logic [N_CH-1:0] mask, input logic [N_CH*W-1:0] bus,
                         input logic full, input logic do_push);
        @(negedge CLK);
        TCP_TX_FULL = full;
        CH_WE       = mask;
        CH_DATA     = bus;
        if (do_push) begin
            for (int i = 0; i < N_CH; i++)
                if (mask[i]) exp_q[i].push_back(bus[i*W +: W]);
        end
    endtask

    task automatic cyc(input logic [N_CH-1:0] mask, input logic full);
        logic [N_CH*W-1:0] bus;
        for (int i = 0; i < N_CH; i++) bus[i*W +: W] = W'($urandom);
        cyc_d(mask, bus, full, 1'b1);
    endtask

    task automatic push_frm(input int ch, input int len);
        frm_t f;
        f.ch  = ch;
        f.len = len;
        exp_frm.push_back(f);
    endtask

    task automatic drain(input string name, input int max_cyc);
        int  n;
        logic done;
        done = 1'b0;
        n = 0;
        while (!done && n < max_cyc) begin
            cyc(4'b0, 1'b0);
            n++;
            done = (exp_frm.size() == 0) && !BUSY && (pst == 0);
            for (int i = 0; i < N_CH; i++) if (exp_q[i].size() != 0) done = 1'b0;
        end
        chk(name, done, 1'b1);
    endtask

    logic [N_CH*W-1:0] bus1;
    int n_wr;

    initial begin
        SYS_RSTn = 1'b0; SOFT_RESET = 1'b0; TCP_OPEN_ACK = 1'b1; TCP_TX_FULL = 1'b0;
        CH_WE = '0; CH_DATA = '0; raw_we = '0; raw_data = '0; raw_full = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_wr", TCP_TX_WR, 1'b0);
        chk("rst_data", TCP_TX_DATA, 8'h00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_pfull", CH_PFULL, 4'h0);
        chk("rst_ovf", CH_OVF, 4'h0);
        SYS_RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        // single word on ch2: A5 02 01 12 34, first WR two edges after the write edge
        bus1 = '0;
        bus1[2*W +: W] = 16'h1234;
        push_frm(2, 1);
        cyc_d(4'b0100, bus1, 1'b0, 1'b1);
        cyc(4'b0, 1'b0);
        chk("lat_wr_n", TCP_TX_WR, 1'b0);
        cyc(4'b0, 1'b0);
        chk("lat_busy_n1", BUSY, 1'b1);
        chk("lat_wr_n1", TCP_TX_WR, 1'b0);
        cyc(4'b0, 1'b0);
        chk("lat_wr_n2", TCP_TX_WR, 1'b1);
        chk("lat_data_n2", TCP_TX_DATA, 8'hA5);
        drain("drain_single", 50);

        // round robin from a fresh pointer
        @(negedge CLK); SOFT_RESET = 1'b1;
        @(negedge CLK); SOFT_RESET = 1'b0;
        cyc(4'b1001, 1'b1);
        cyc(4'b1001, 1'b1);
        push_frm(0, 2); push_frm(3, 2);
        drain("drain_rr1", 100);
        cyc(4'b1001, 1'b1);
        push_frm(0, 1); push_frm(3, 1);
        drain("drain_rr2", 100);

        // burst cap
        repeat (100) cyc(4'b0010, 1'b1);
        push_frm(1, MAXB); push_frm(1, 100 - MAXB);
        drain("drain_burst", 1000);

        // backpressure mid-payload
        repeat (40) cyc(4'b0100, 1'b1);
        push_frm(2, 40);
        repeat (16) cyc(4'b0, 1'b0);
        n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0, 1'b1);
            if (i > 0 && TCP_TX_WR) n_wr++;
        end
        chk("bp_busy", BUSY, 1'b1);
        chk("bp_wr_after_rise", n_wr <= 1, 1'b1);
        drain("drain_bp", 500);

        // randomized traffic with random backpressure
        repeat (400) cyc(($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'b0,
                         $urandom_range(0, 9) < 3);
        drain("drain_random", 4000);

        // overflow and prog-full on ch0
        repeat (959) cyc(4'b0001, 1'b1);
        cyc(4'b0, 1'b1);
        chk("pfull_959", CH_PFULL[0], 1'b0);
        cyc(4'b0001, 1'b1);
        cyc(4'b0, 1'b1);
        chk("pfull_960", CH_PFULL[0], 1'b1);
        repeat (64) cyc(4'b0001, 1'b1);
        cyc(4'b0, 1'b1);
        chk("ovf_at_1024", CH_OVF, 4'h0);
        cyc_d(4'b0001, {4{16'hDEAD}}, 1'b1, 1'b0);
        cyc(4'b0, 1'b1);
        chk("ovf_set", CH_OVF, 4'h1);
        for (int i = 0; i < 16; i++) push_frm(0, MAXB);
        drain("drain_ovf", 4000);
        chk("pfull_after_drain", CH_PFULL, 4'h0);
        chk("ovf_sticky", CH_OVF, 4'h1);

        // flush mid-frame
        repeat (20) cyc(4'b0010, 1'b1);
        repeat (10) cyc(4'b0, 1'b0);
        chk("pre_flush_busy", BUSY, 1'b1);
        @(negedge CLK); TCP_OPEN_ACK = 1'b0;
        @(negedge CLK);
        chk("flush_wr_now", TCP_TX_WR, 1'b0);
        chk("flush_busy", BUSY, 1'b0);
        chk("flush_ovf", CH_OVF, 4'h0);
        TCP_OPEN_ACK = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0, 1'b0);
            chk("post_flush_idle", {BUSY, TCP_TX_WR}, 2'b00);
        end

        // unframed instance: payload bytes only
        @(negedge CLK);
        raw_data = '0;
        raw_data[2*W +: W] = 16'h1234;
        raw_we = 4'b0100;
        exp_raw.push_back(8'h12);
        exp_raw.push_back(8'h34);
        @(negedge CLK); raw_we = '0;
        chk("raw_wr_n", raw_wr, 1'b0);
        @(negedge CLK);
        chk("raw_busy_n1", raw_busy, 1'b1);
        @(negedge CLK);
        chk("raw_wr_n2", raw_wr, 1'b1);
        @(negedge CLK);
        chk("raw_wr_n3", raw_wr, 1'b1);
        @(negedge CLK);
        chk("raw_idle", {raw_busy, raw_wr}, 2'b00);
        chk("raw_q_empty", exp_raw.size(), 0);
        chk("raw_flags", {raw_pfull, raw_ovf}, 8'h00);

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
